serial_comparator_msf_framed: RTL and testbench
===============================================

Name: serial_comparator_msf_framed

Overview:
- Framed, parametrised MSB-first serial magnitude comparator.
- Accepts DIGIT_W-bit digits of operands a and b, most significant digit first, under a valid/last handshake, with optional per-frame signed (two's complement) mode.
- Produces one registered result (lt/eq/gt plus length-error flag) per frame.
- Sits behind serial links / bit-serial datapaths that need word compares without deserialising.

Parameters:
- DIGIT_W, 1, bits per digit per cycle (>=1).
- WORD_DIGITS, 8, maximum digits per frame (>=1); frame auto-terminates at this count.
- CNT_W, $clog2(WORD_DIGITS+1), derived digit-counter width (localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; all state to reset values.
- clr  in  1  synchronous abort of the current frame.
- in_valid  in  1  digit pair present this cycle.
- in_last  in  1  qualifies the final digit of the frame (valid only with in_valid).
- signed_mode  in  1  sampled on the first digit of a frame; 1 = two's complement compare.
- a  in  DIGIT_W  digit of operand A.
- b  in  DIGIT_W  digit of operand B.
- res_valid  out  1  one-cycle pulse, result of the completed frame.
- a_less_b  out  1  registered result, held until the next res_valid.
- a_eq_b  out  1  registered result, held.
- a_greater_b  out  1  registered result, held.
- len_err  out  1  registered; frame length did not equal WORD_DIGITS with in_last on the final digit.

Behaviour:
- Reset (async): state IDLE, cnt=0, running result EQ, res_valid=0, a_less_b=a_eq_b=a_greater_b=0, len_err=0.
- States:
  - IDLE: waiting for the first digit.
  - BUSY: mid-frame.
- in_valid=0 stalls: no state, counter or result change; res_valid=0.
- First digit (IDLE & in_valid):
  - Latch signed_mode for the frame.
  - Compare digits; if signed_mode, compare the first digit as signed DIGIT_W values, otherwise unsigned.
  - Running result = LT/EQ/GT.
- Later digits (BUSY & in_valid):
  - Always unsigned compare.
  - Running result updates only while it is still EQ; once LT/GT is decided, later digits are ignored but still counted.
- Frame end occurs on the accepted digit where in_last=1 OR cnt==WORD_DIGITS-1, whichever comes first.
  - Next cycle: res_valid=1 and the final result is loaded into the three flags (exactly one set).
  - len_err=1 if terminated by the cap without in_last, or by in_last with cnt<WORD_DIGITS-1.
  - State returns to IDLE, cnt=0, running result EQ.
- Single-digit frames (in_last on the first digit) are legal.
  - Back-to-back frames give consecutive res_valid pulses with no bubble.
  - A digit in the cycle after frame end starts a new frame.
- Latency: res_valid one cycle after the last digit is accepted.
- Digits arriving after a cap termination belong to a new frame; there is no resync to in_last.
- clr:
  - Returns to IDLE, cnt=0, running result EQ; the coincident digit is discarded.
  - Suppresses the result of the aborted frame, even if that digit carried in_last.
  - Held outputs keep the previous result; a res_valid already in flight (previous frame) still fires.
- in_last with in_valid=0 is ignored.
- Async reset mid-frame discards the frame immediately; outputs return to reset values.

Decomposition:
- Package serial_cmp_pkg:
  - cmp_result_t enum {CMP_EQ, CMP_LT, CMP_GT}.
  - state_t enum {ST_IDLE, ST_BUSY}.
  - Function to one-hot-decode cmp_result_t to {lt, eq, gt}.
- Sub-module serial_cmp_digit (combinational, parameter DIGIT_W):
  - Inputs a, b, is_signed.
  - Output cmp_result_t.
  - Instantiated once.
- Top holds the FSM, counter, frame mode register and result registers.

Test Plan:
- DIGIT_W=1, WORD_DIGITS=8, unsigned: a=0x5A, b=0x5C MSB-first, in_last on digit 8 -> res_valid one cycle later, a_less_b=1, len_err=0; a=b=0xA5 -> a_eq_b=1.
- Signed: a=0x80, b=0x01 with signed_mode=1 -> a_less_b=1; same operands with signed_mode=0 -> a_greater_b=1; signed_mode toggled mid-frame has no effect.
- DIGIT_W=4, WORD_DIGITS=2: a=0x3F, b=0x3E -> gt; back-to-back second frame a=0x10, b=0x20 -> consecutive res_valid pulses, lt; in_valid gaps of 3 cycles inserted -> same results, shifted.
- Length: in_last on digit 3 of 8 with a=101, b=100 -> gt, len_err=1; 8 digits with no in_last -> result after digit 8, len_err=1, digit 9 starts a new frame.
- clr asserted on digit 5 (and separately on the in_last digit) -> no res_valid, outputs hold the prior result; next frame compares correctly.
- Async rst asserted mid-frame between clock edges -> outputs clear immediately, res_valid=0; the following frame is correct.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// ============================================================================
// Module      : serial_cmp_pkg
// Description : Shared types and result decode for the framed serial comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_LT = 2'd1,
    CMP_GT = 2'd2
  } cmp_result_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Returns {lt, eq, gt}; the unused encoding falls back to EQ.
  function automatic logic [2:0] decode_cmp(input cmp_result_t r);
    logic [2:0] v;
    case (r)
      CMP_LT:  v = 3'b100;
      CMP_GT:  v = 3'b001;
      default: v = 3'b010;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_cmp_digit.sv
// ============================================================================
// Module      : serial_cmp_digit
// Description : Combinational single-digit magnitude compare, signed or unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_cmp_digit
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               is_signed,
  output cmp_result_t        result
);

  logic [DIGIT_W-1:0] w_bias;
  logic [DIGIT_W-1:0] w_a;
  logic [DIGIT_W-1:0] w_b;

  // Flipping the sign bit maps two's complement order onto unsigned order.
  assign w_bias = DIGIT_W'(is_signed) << (DIGIT_W - 1);
  assign w_a    = a ^ w_bias;
  assign w_b    = b ^ w_bias;

  always_comb begin
    result = CMP_EQ;
    if (w_a < w_b) begin
      result = CMP_LT;
    end else if (w_a > w_b) begin
      result = CMP_GT;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_comparator_msf_framed.sv
// ============================================================================
// Module      : serial_comparator_msf_framed
// Description : Framed MSB-first serial magnitude comparator, one result per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_comparator_msf_framed
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic               signed_mode,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               res_valid,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b,
  output logic               len_err
);

  localparam int CNT_W = $clog2(WORD_DIGITS + 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WORD_DIGITS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  cmp_result_t      r_run;

  cmp_result_t w_dig;
  cmp_result_t w_next;
  logic        w_first_signed;
  logic        w_full;
  logic        w_end;

  // Only the leading digit carries a sign; the mode is taken from that digit alone.
  assign w_first_signed = (r_state == ST_IDLE) & signed_mode;

  serial_cmp_digit #(
    .DIGIT_W (DIGIT_W)
  ) u_digit (
    .a         (a),
    .b         (b),
    .is_signed (w_first_signed),
    .result    (w_dig)
  );

  assign w_next = (r_run == CMP_EQ) ? w_dig : r_run;
  assign w_full = (r_cnt == c_CNT_LAST);
  assign w_end  = in_last | w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_run       <= CMP_EQ;
      res_valid   <= 1'b0;
      a_less_b    <= 1'b0;
      a_eq_b      <= 1'b0;
      a_greater_b <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (clr) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_run   <= CMP_EQ;
      end else if (in_valid) begin
        if (w_end) begin
          res_valid                          <= 1'b1;
          {a_less_b, a_eq_b, a_greater_b}    <= decode_cmp(w_next);
          len_err                            <= ~(in_last & w_full);
          r_state                            <= ST_IDLE;
          r_cnt                              <= '0;
          r_run                              <= CMP_EQ;
        end else begin
          r_state <= ST_BUSY;
          r_cnt   <= r_cnt + CNT_W'(1);
          r_run   <= w_next;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_comparator_msf_framed.sv
// ============================================================================
// Module      : tb_serial_comparator_msf_framed
// Description : Randomised and directed bench for two comparator configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_comparator_msf_framed;

  logic clk;
  logic rst;

  logic       m_v  [2];
  logic       m_l  [2];
  logic       m_sm [2];
  logic       m_c  [2];
  logic [3:0] m_a  [2];
  logic [3:0] m_b  [2];

  logic o_rv [2];
  logic o_lt [2];
  logic o_eq [2];
  logic o_gt [2];
  logic o_le [2];

  int DWS [2] = '{1, 4};
  int WDS [2] = '{8, 2};

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_comparator_msf_framed #(.DIGIT_W(1), .WORD_DIGITS(8)) u_dut0 (
    .clk (clk), .rst (rst), .clr (m_c[0]), .in_valid (m_v[0]), .in_last (m_l[0]),
    .signed_mode (m_sm[0]), .a (m_a[0][0:0]), .b (m_b[0][0:0]),
    .res_valid (o_rv[0]), .a_less_b (o_lt[0]), .a_eq_b (o_eq[0]),
    .a_greater_b (o_gt[0]), .len_err (o_le[0])
  );

  serial_comparator_msf_framed #(.DIGIT_W(4), .WORD_DIGITS(2)) u_dut1 (
    .clk (clk), .rst (rst), .clr (m_c[1]), .in_valid (m_v[1]), .in_last (m_l[1]),
    .signed_mode (m_sm[1]), .a (m_a[1]), .b (m_b[1]),
    .res_valid (o_rv[1]), .a_less_b (o_lt[1]), .a_eq_b (o_eq[1]),
    .a_greater_b (o_gt[1]), .len_err (o_le[1])
  );

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: collect whole operands per frame, compare as integers.
  int     r_n  [2];
  longint r_ua [2];
  longint r_ub [2];
  bit     r_sm [2];
  logic   e_rv [2];
  logic   e_lt [2];
  logic   e_eq [2];
  logic   e_gt [2];
  logic   e_le [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        r_n[k] = 0; e_rv[k] = 0; e_lt[k] = 0; e_eq[k] = 0; e_gt[k] = 0; e_le[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        e_rv[k] = 0;
        if (m_c[k]) begin
          r_n[k] = 0;
        end else if (m_v[k]) begin
          longint dmask;
          dmask = (64'd1 << DWS[k]) - 1;
          if (r_n[k] == 0) begin
            r_sm[k] = m_sm[k]; r_ua[k] = 0; r_ub[k] = 0;
          end
          r_ua[k] = (r_ua[k] << DWS[k]) | (longint'(m_a[k]) & dmask);
          r_ub[k] = (r_ub[k] << DWS[k]) | (longint'(m_b[k]) & dmask);
          r_n[k]++;
          if (m_l[k] || r_n[k] == WDS[k]) begin
            int     w;
            longint sa, sb;
            w  = r_n[k] * DWS[k];
            sa = r_ua[k];
            sb = r_ub[k];
            if (r_sm[k]) begin
              if (sa >= (64'd1 << (w - 1))) sa = sa - (64'd1 << w);
              if (sb >= (64'd1 << (w - 1))) sb = sb - (64'd1 << w);
            end
            e_lt[k] = (sa < sb);
            e_eq[k] = (sa == sb);
            e_gt[k] = (sa > sb);
            e_le[k] = !(m_l[k] && r_n[k] == WDS[k]);
            e_rv[k] = 1;
            r_n[k]  = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("res_valid%0d", k), o_rv[k], e_rv[k]);
      check($sformatf("a_less_b%0d", k), o_lt[k], e_lt[k]);
      check($sformatf("a_eq_b%0d", k), o_eq[k], e_eq[k]);
      check($sformatf("a_greater_b%0d", k), o_gt[k], e_gt[k]);
      check($sformatf("len_err%0d", k), o_le[k], e_le[k]);
    end
  end

  task automatic drive(input int k, input logic v, input logic l, input logic sm,
                       input logic [3:0] da, input logic [3:0] db, input logic c);
    @(negedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      m_v[j] = 0; m_l[j] = 0; m_sm[j] = 0; m_c[j] = 0; m_a[j] = 0; m_b[j] = 0;
    end
    m_v[k] = v; m_l[k] = l; m_sm[k] = sm; m_a[k] = da; m_b[k] = db; m_c[k] = c;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 0, 0, 0, 4'd0, 4'd0, 0);
  endtask

  task automatic send_frame(input int k, input int av, input int bv, input int nd,
                            input logic sm, input logic use_last, input int gap,
                            input int clr_idx, input logic toggle);
    int mask;
    mask = (1 << DWS[k]) - 1;
    for (int i = 0; i < nd; i++) begin
      int   sh;
      logic smi;
      sh  = (nd - 1 - i) * DWS[k];
      smi = (i == 0) ? sm : (toggle ? ~sm : sm);
      if (i > 0) idle(gap);
      drive(k, 1, use_last && (i == nd - 1), smi,
            4'((av >> sh) & mask), 4'((bv >> sh) & mask), i == clr_idx);
      if (i == clr_idx) break;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int j = 0; j < 2; j++) begin
      m_v[j] = 0; m_l[j] = 0; m_sm[j] = 0; m_c[j] = 0; m_a[j] = 0; m_b[j] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    send_frame(0, 'h5A, 'h5C, 8, 0, 1, 0, -1, 0);
    send_frame(0, 'hA5, 'hA5, 8, 0, 1, 0, -1, 0);
    send_frame(0, 'h80, 'h01, 8, 1, 1, 0, -1, 0);
    send_frame(0, 'h80, 'h01, 8, 0, 1, 0, -1, 0);
    send_frame(0, 'h80, 'h01, 8, 1, 1, 0, -1, 1);
    send_frame(0, 'h5, 'h4, 3, 0, 1, 0, -1, 0);
    send_frame(0, 'h12, 'h34, 8, 0, 0, 0, -1, 0);
    send_frame(0, 'h1, 'h0, 1, 0, 1, 0, -1, 0);
    idle(2);
    send_frame(0, 'h5A, 'h3C, 8, 0, 1, 0, 4, 0);
    idle(2);
    send_frame(0, 'h3C, 'h5A, 8, 0, 1, 0, 7, 0);
    idle(2);
    send_frame(0, 'h77, 'h70, 8, 0, 1, 0, -1, 0);

    send_frame(1, 'h3F, 'h3E, 2, 0, 1, 0, -1, 0);
    send_frame(1, 'h10, 'h20, 2, 0, 1, 0, -1, 0);
    send_frame(1, 'h3F, 'h3E, 2, 0, 1, 3, -1, 0);
    idle(3);
    send_frame(1, 'h10, 'h20, 2, 0, 1, 3, -1, 0);
    send_frame(1, 'h90, 'h10, 2, 1, 1, 0, -1, 0);
    idle(2);

    send_frame(0, 'hF0, 'h0F, 3, 0, 0, 0, -1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("async_rst_res_valid", o_rv[k], 0);
      check("async_rst_lt", o_lt[k], 0);
      check("async_rst_eq", o_eq[k], 0);
      check("async_rst_gt", o_gt[k], 0);
      check("async_rst_len_err", o_le[k], 0);
    end
    for (int j = 0; j < 2; j++) begin
      m_v[j] = 0; m_l[j] = 0; m_c[j] = 0;
    end
    @(negedge clk);
    #2 rst = 1'b0;
    send_frame(0, 'h33, 'h34, 8, 0, 1, 0, -1, 0);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      int         k;
      logic [3:0] ra;
      logic [3:0] rb;
      k  = int'($urandom_range(0, 1));
      ra = 4'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? ra : 4'($urandom);
      drive(k, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            1'($urandom), ra, rb, $urandom_range(0, 19) == 0);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
